// File: rtl/stat_bist_pkg.sv
// ---------------------------------------------------------------------------
// stat_bist_pkg
// Shared definitions for the Stat benchmark self-test controller:
//   WIDTH        - datapath width of pattern generator and signature register
//   POLY         - Galois feedback taps for x^32+x^22+x^2+x+1
//   bist_state_t - controller state encoding
//   eff_seed()   - maps an all-zero seed to 1 (zero is a lock-up state)
//   galois_step()- one shift of the Galois register with an XOR-in word
// ---------------------------------------------------------------------------
package stat_bist_pkg;

  localparam int unsigned WIDTH = 32;
  localparam logic [WIDTH-1:0] POLY = 32'h0040_0007;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } bist_state_t;

  function automatic logic [WIDTH-1:0] eff_seed(input logic [WIDTH-1:0] s);
    return (s == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : s;
  endfunction

  function automatic logic [WIDTH-1:0] galois_step(input logic [WIDTH-1:0] s,
                                                   input logic [WIDTH-1:0] din);
    return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? POLY : '0) ^ din;
  endfunction

endpackage

// File: rtl/stat_bist_ctrl_lfsr.sv
// ---------------------------------------------------------------------------
// stat_lfsr32
// Galois shift register used both as the pattern LFSR (din tied to 0) and as
// the output-compacting MISR (din = benchmark outputs).
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset to RESET_VAL
//   load     in   load load_val (has priority over en)
//   load_val in   WIDTH value to load
//   en       in   advance one step, absorbing din
//   din      in   WIDTH word XORed into the next state
//   q        out  WIDTH current register contents
// ---------------------------------------------------------------------------
module stat_lfsr32
  import stat_bist_pkg::*;
#(
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] val_q;
  logic [WIDTH-1:0] val_d;

  always_comb begin
    val_d = val_q;
    if (load) begin
      val_d = load_val;
    end else if (en) begin
      val_d = galois_step(val_q, din);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= RESET_VAL;
    end else begin
      val_q <= val_d;
    end
  end

  assign q = val_q;

endmodule

// File: rtl/stat_bist_ctrl.sv
// ---------------------------------------------------------------------------
// stat_bist_ctrl
// Self-test controller for the 32-in/32-out Stat benchmark netlists. Drives
// the benchmark inputs from an LFSR, compacts its outputs in a MISR and, after
// NUM_PATTERNS captures, publishes the signature and its golden compare.
//
// Build option: define STAT_BIST_SETTLE_EN to hold each pattern for
// SETTLE_CYCLES extra cycles before it is captured.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset
//   start   in   session request, honoured only in IDLE
//   pat_out out  32 pattern to benchmark inputs (bit 0 = n1), registered
//   dut_in  in   32 benchmark outputs (bit 0 = first output)
//   busy    out  session in progress (SETTLE or RUN)
//   done    out  one-cycle pulse when sig/pass become valid
//   sig     out  32 final MISR signature, cleared on accepted start
//   pass    out  sig == GOLDEN, held with sig
//
// state  | meaning
// IDLE   | waiting for start; outputs hold previous session results
// SETTLE | pattern on pat_out, waiting for the benchmark to settle
// RUN    | capture cycle: MISR absorbs dut_in, LFSR and counter advance
// DONE   | signature valid, done pulse
// ---------------------------------------------------------------------------
module stat_bist_ctrl
  import stat_bist_pkg::*;
#(
  parameter logic [WIDTH-1:0] SEED          = 32'h0000_0001,
  parameter int unsigned      NUM_PATTERNS  = 1024,
  parameter logic [WIDTH-1:0] GOLDEN        = 32'h0000_0000,
  parameter int unsigned      SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] pat_out,
  input  logic [WIDTH-1:0] dut_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sig,
  output logic             pass
);

  localparam int unsigned      CW        = $clog2(NUM_PATTERNS + 1);
  localparam logic [CW-1:0]    CNT_LAST  = CW'(NUM_PATTERNS - 1);
  localparam int unsigned      SW        = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0]    SETTLE_LD = SW'(SETTLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] SEED_EFF  = eff_seed(SEED);

  // State entered whenever a new pattern appears on pat_out.
`ifdef STAT_BIST_SETTLE_EN
  localparam bist_state_t PAT_STATE = SETTLE;
`else
  localparam bist_state_t PAT_STATE = RUN;
`endif

  bist_state_t      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic             pass_q, pass_d;

  logic             gen_load, gen_en;
  logic             cmp_load, cmp_en;
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] misr_q;
  logic [WIDTH-1:0] misr_nxt;

  stat_lfsr32 #(
    .RESET_VAL (SEED_EFF)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (gen_load),
    .load_val (SEED_EFF),
    .en       (gen_en),
    .din      ('0),
    .q        (lfsr_q)
  );

  stat_lfsr32 #(
    .RESET_VAL ('0)
  ) u_misr (
    .clk      (clk),
    .rst      (rst),
    .load     (cmp_load),
    .load_val ('0),
    .en       (cmp_en),
    .din      (dut_in),
    .q        (misr_q)
  );

  // Value the MISR takes at the end of a capture cycle; the last capture
  // publishes it directly so sig is valid in the DONE cycle itself.
  assign misr_nxt = galois_step(misr_q, dut_in);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    pat_d    = pat_q;
    sig_d    = sig_q;
    pass_d   = pass_q;
    gen_load = 1'b0;
    gen_en   = 1'b0;
    cmp_load = 1'b0;
    cmp_en   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          gen_load = 1'b1;
          cmp_load = 1'b1;
          cnt_d    = '0;
          settle_d = SETTLE_LD;
          pat_d    = SEED_EFF;
          sig_d    = '0;
          pass_d   = 1'b0;
          state_d  = PAT_STATE;
        end
      end

      SETTLE: begin
        if (settle_q == '0) begin
          state_d = RUN;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end

      RUN: begin
        gen_en = 1'b1;
        cmp_en = 1'b1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          // pat_out keeps the last pattern until the next session.
          sig_d   = misr_nxt;
          pass_d  = (misr_nxt == GOLDEN);
          state_d = DONE;
        end else begin
          pat_d    = galois_step(lfsr_q, '0);
          settle_d = SETTLE_LD;
          state_d  = PAT_STATE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      settle_q <= '0;
      pat_q    <= '0;
      sig_q    <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      pat_q    <= pat_d;
      sig_q    <= sig_d;
      pass_q   <= pass_d;
    end
  end

  assign pat_out = pat_q;
  assign busy    = (state_q == RUN) || (state_q == SETTLE);
  assign done    = (state_q == DONE);
  assign sig     = sig_q;
  assign pass    = pass_q;

endmodule

// File: tb/tb_stat_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stat_bist_ctrl
// Three controller instances with different seeds/pattern counts share one
// clock. A cycle-indexed reference model tracks each session by its position
// in time (pattern k occupies cycles 1+k*C .. (k+1)*C, capture on the last
// cycle of each slot, done one cycle after the final capture) and is compared
// against every output on every falling edge. Literal checks pin the model.
// ---------------------------------------------------------------------------
module tb_stat_bist_ctrl;

`ifdef STAT_BIST_SETTLE_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif
  localparam int C = S + 1;
  localparam logic [31:0] TB_POLY = 32'h0040_0007;

  localparam logic [31:0] SD0 = 32'h0000_0000;
  localparam logic [31:0] SD1 = 32'h8000_0000;
  localparam logic [31:0] SD2 = 32'h1357_9BDF;
  localparam int          NP0 = 3;
  localparam int          NP1 = 2;
  localparam int          NP2 = 8;

  logic        clk;
  logic [2:0]  rst_v;
  logic [2:0]  start_v;
  logic [31:0] pat_o  [3];
  logic [31:0] sig_o  [3];
  logic        busy_o [3];
  logic        done_o [3];
  logic        pass_o [3];
  logic [31:0] din_v  [3];
  logic        mode2;
  logic [31:0] rnd2;

  int total;
  int bad;
  int donecnt [3];

  // reference model state
  bit          act    [3];
  int          tcyc   [3];
  int          caps   [3];
  logic [31:0] lf     [3];
  logic [31:0] misr   [3];
  logic [31:0] pat_e  [3];
  logic [31:0] sig_e  [3];
  logic        pass_e [3];
  logic        busy_e [3];
  logic        done_e [3];
  logic [31:0] sd_m   [3];
  int          np_m   [3];

  function automatic logic [31:0] lstep(input logic [31:0] s);
    return {s[30:0], 1'b0} ^ (s[31] ? TB_POLY : 32'h0);
  endfunction

  function automatic logic [31:0] eff(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  // stand-in for the benchmark's combinational logic
  function automatic logic [31:0] bench_fn(input logic [31:0] p);
    return {p[15:0] ^ p[31:16], p[7:0] + p[23:16], ~p[15:8]};
  endfunction

  assign din_v[0] = 32'h0;
  assign din_v[1] = 32'h1;
  assign din_v[2] = mode2 ? bench_fn(pat_o[2]) : rnd2;

  stat_bist_ctrl #(.SEED(SD0), .NUM_PATTERNS(NP0), .GOLDEN(32'h0), .SETTLE_CYCLES(2)) u0 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .pat_out(pat_o[0]), .dut_in(din_v[0]),
    .busy(busy_o[0]), .done(done_o[0]), .sig(sig_o[0]), .pass(pass_o[0]));

  stat_bist_ctrl #(.SEED(SD1), .NUM_PATTERNS(NP1), .GOLDEN(32'h0), .SETTLE_CYCLES(2)) u1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .pat_out(pat_o[1]), .dut_in(din_v[1]),
    .busy(busy_o[1]), .done(done_o[1]), .sig(sig_o[1]), .pass(pass_o[1]));

  stat_bist_ctrl #(.SEED(SD2), .NUM_PATTERNS(NP2), .GOLDEN(32'h0), .SETTLE_CYCLES(2)) u2 (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .pat_out(pat_o[2]), .dut_in(din_v[2]),
    .busy(busy_o[2]), .done(done_o[2]), .sig(sig_o[2]), .pass(pass_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, a, e, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // compare, then advance the model with the inputs about to be sampled
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d pat_out", i), pat_o[i], pat_e[i]);
      chk($sformatf("u%0d busy", i), 32'(busy_o[i]), 32'(busy_e[i]));
      chk($sformatf("u%0d done", i), 32'(done_o[i]), 32'(done_e[i]));
      chk($sformatf("u%0d sig", i), sig_o[i], sig_e[i]);
      chk($sformatf("u%0d pass", i), 32'(pass_o[i]), 32'(pass_e[i]));
      if (done_o[i] === 1'b1) donecnt[i]++;
    end
    for (int i = 0; i < 3; i++) begin
      if (rst_v[i]) begin
        act[i] = 0; pat_e[i] = '0; sig_e[i] = '0; pass_e[i] = 0;
        busy_e[i] = 0; done_e[i] = 0;
      end else if (!act[i]) begin
        if (start_v[i]) begin
          act[i] = 1; tcyc[i] = 1; caps[i] = 0;
          lf[i] = eff(sd_m[i]); pat_e[i] = lf[i]; misr[i] = '0;
          sig_e[i] = '0; pass_e[i] = 0; busy_e[i] = 1; done_e[i] = 0;
        end
      end else if (tcyc[i] > np_m[i] * C) begin
        act[i] = 0; busy_e[i] = 0; done_e[i] = 0;
      end else begin
        if (tcyc[i] % C == 0) begin
          misr[i] = lstep(misr[i]) ^ din_v[i];
          caps[i]++;
          if (caps[i] == np_m[i]) begin
            sig_e[i]  = misr[i];
            pass_e[i] = (misr[i] == 32'h0);
          end else begin
            lf[i]    = lstep(lf[i]);
            pat_e[i] = lf[i];
          end
        end
        tcyc[i]++;
        busy_e[i] = (tcyc[i] <= np_m[i] * C);
        done_e[i] = (tcyc[i] == np_m[i] * C + 1);
      end
    end
  end

  logic [31:0] exp0 [3];
  logic [31:0] golden_a;
  int          base;

  initial begin
    total = 0; bad = 0;
    sd_m[0] = SD0; sd_m[1] = SD1; sd_m[2] = SD2;
    np_m[0] = NP0; np_m[1] = NP1; np_m[2] = NP2;
    for (int i = 0; i < 3; i++) begin
      act[i] = 0; tcyc[i] = 0; caps[i] = 0; lf[i] = '0; misr[i] = '0;
      pat_e[i] = '0; sig_e[i] = '0; pass_e[i] = 0; busy_e[i] = 0; done_e[i] = 0;
      donecnt[i] = 0;
    end
    exp0[0] = 32'h1; exp0[1] = 32'h2; exp0[2] = 32'h4;
    mode2 = 1'b1; rnd2 = '0;

    // reset with start held high: start must have no effect
    rst_v = 3'b111; start_v = 3'b111;
    repeat (3) step();
    rst_v = 3'b000; start_v = 3'b000;
    repeat (2) step();
    for (int i = 0; i < 3; i++) begin
      chk("idle pat_out", pat_o[i], 32'h0);
      chk("idle busy", 32'(busy_o[i]), 32'h0);
      chk("idle done", 32'(done_o[i]), 32'h0);
      chk("idle sig", sig_o[i], 32'h0);
      chk("idle pass", 32'(pass_o[i]), 32'h0);
    end

    // u0: zero seed -> 1, patterns 1,2,4; starts at cycle 2 and done cycle ignored
    base = donecnt[0];
    start_v[0] = 1'b1; step(); start_v[0] = 1'b0;
    for (int t = 1; t <= 3 * C + 2; t++) begin
      if (t <= 3 * C) chk("u0 pattern literal", pat_o[0], exp0[(t - 1) / C]);
      if (t <= 3 * C) chk("u0 busy literal", 32'(busy_o[0]), 32'h1);
      if (t == 3 * C + 1) begin
        chk("u0 done literal", 32'(done_o[0]), 32'h1);
        chk("u0 busy at done", 32'(busy_o[0]), 32'h0);
        chk("u0 sig literal", sig_o[0], 32'h0);
        chk("u0 pass literal", 32'(pass_o[0]), 32'h1);
      end
      start_v[0] = (t == 2) || (t == 3 * C + 1) || (t == 3 * C + 2);
      step();
    end
    start_v[0] = 1'b0;
    chk("u0 done count", 32'(donecnt[0] - base), 32'h1);
    chk("u0 restart busy", 32'(busy_o[0]), 32'h1);
    chk("u0 restart pat", pat_o[0], 32'h1);
    repeat (3 * C + 2) step();

    // u1: seed 8000_0000, dut_in = 1 -> sig 3, pass 0
    start_v[1] = 1'b1; step(); start_v[1] = 1'b0;
    for (int t = 1; t <= 2 * C + 1; t++) begin
      if (t == 1) chk("u1 first pattern", pat_o[1], 32'h8000_0000);
      if (t == 1 + C) chk("u1 second pattern", pat_o[1], 32'h0040_0007);
      if (t == 2 * C + 1) begin
        chk("u1 done literal", 32'(done_o[1]), 32'h1);
        chk("u1 sig literal", sig_o[1], 32'h0000_0003);
        chk("u1 pass literal", 32'(pass_o[1]), 32'h0);
      end
      step();
    end
    repeat (2) step();

    // u2: full session on the benchmark stand-in
    start_v[2] = 1'b1; step(); start_v[2] = 1'b0;
    repeat (8 * C + 2) step();
    golden_a = sig_e[2];

    // aborted session: reset sampled at end of cycle 4
    base = donecnt[2];
    start_v[2] = 1'b1; step(); start_v[2] = 1'b0;
    repeat (3) step();
    rst_v[2] = 1'b1; step(); rst_v[2] = 1'b0;
    chk("abort pat_out", pat_o[2], 32'h0);
    chk("abort busy", 32'(busy_o[2]), 32'h0);
    chk("abort sig", sig_o[2], 32'h0);
    chk("abort pass", 32'(pass_o[2]), 32'h0);
    repeat (8 * C + 4) step();
    chk("abort no done", 32'(donecnt[2] - base), 32'h0);

    // fresh session reproduces the full-session signature
    start_v[2] = 1'b1; step(); start_v[2] = 1'b0;
    repeat (8 * C) step();
    chk("repeat done", 32'(done_o[2]), 32'h1);
    chk("repeat sig", sig_o[2], golden_a);
    repeat (2) step();

    // randomized starts, resets and capture data
    mode2 = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      rnd2 = $urandom;
      for (int i = 0; i < 3; i++) begin
        start_v[i] = ($urandom_range(0, 5) == 0);
        rst_v[i]   = ($urandom_range(0, 149) == 0);
      end
      if (n == 2000) mode2 = 1'b1;
      step();
    end
    rst_v = 3'b000; start_v = 3'b000;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
